// File: rtl/fb_column_writer.sv
// Column-to-strip expander feeding the double-buffered RGB565 frame buffer.
// Each accepted wall descriptor becomes SCREEN_HEIGHT ceiling/wall/floor pixels, one per clock.
module fb_column_writer #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 180,
    parameter logic [15:0] CEIL_COLOR    = 16'h31A6,
    parameter logic [15:0] FLOOR_COLOR   = 16'h8410
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        col_valid_in,
    output logic        col_ready_out,
    input  logic [8:0]  col_x_in,
    input  logic [7:0]  col_height_in,
    input  logic [15:0] col_color_in,
    input  logic        col_side_in,
    input  logic        col_last_in,
    input  logic        frame_swap_in,
    output logic        ray_valid_out,
    output logic [15:0] ray_address_out,
    output logic [15:0] ray_pixel_out,
    output logic        ray_last_pixel_out
);

    localparam int          DATA_W   = 16;
    localparam logic [7:0]  HEIGHT_L = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]  ROW_LAST = 8'(SCREEN_HEIGHT - 1);
    localparam logic [8:0]  WIDTH_L  = 9'(SCREEN_WIDTH);
    localparam logic [15:0] STRIDE   = 16'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAW      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Heights beyond the screen saturate so the wall simply fills the strip.
    function automatic logic [7:0] sat_height(input logic [7:0] h);
        return (h > HEIGHT_L) ? HEIGHT_L : h;
    endfunction

    function automatic logic [7:0] wall_start(input logic [7:0] h_sat);
        logic [7:0] gap;
        gap = HEIGHT_L - h_sat;
        return gap >> 1;
    endfunction

    // y-side hits are darkened by halving each 5/6/5 channel independently.
    function automatic logic [DATA_W-1:0] shade(input logic [DATA_W-1:0] c, input logic side);
        return side ? {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]} : c;
    endfunction

    function automatic logic [DATA_W-1:0] pick(input logic [7:0] y, input logic [7:0] s,
                                               input logic [7:0] e, input logic [DATA_W-1:0] wall);
        if (y < s)
            return CEIL_COLOR;
        else if (y < e)
            return wall;
        else
            return FLOOR_COLOR;
    endfunction

    logic              accept;
    logic              oob_c;
    logic [7:0]        h_sat_c;
    logic [7:0]        start_c;
    logic [7:0]        end_c;
    logic [DATA_W-1:0] wall_c;

    logic [7:0]        start_p0;
    logic [7:0]        end_p0;
    logic [DATA_W-1:0] wall_p0;
    logic              last_p0;

    logic [7:0]        row_p1;
    logic [7:0]        row_next;
    logic              vld_p1;
    logic [15:0]       addr_p1;
    logic [DATA_W-1:0] pix_p1;
    logic              last_p1;

    assign accept   = col_valid_in && (state_q == IDLE);
    assign oob_c    = (col_x_in >= WIDTH_L);
    assign h_sat_c  = sat_height(col_height_in);
    assign start_c  = wall_start(h_sat_c);
    assign end_c    = start_c + h_sat_c;
    assign wall_c   = shade(col_color_in, col_side_in);
    assign row_next = row_p1 + 8'd1;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        col_ready_out = 1'b0;
        case (state_q)
            IDLE: begin
                col_ready_out = rst_n_in;
                if (col_valid_in) begin
                    if (oob_c)
                        state_d = col_last_in ? WAIT_SWAP : IDLE;
                    else
                        state_d = DRAW;
                end
            end
            DRAW: begin
                if (row_p1 == ROW_LAST)
                    state_d = last_p0 ? WAIT_SWAP : IDLE;
            end
            WAIT_SWAP: begin
                if (frame_swap_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: descriptor capture; only these latched values drive the strip.
    always_ff @(posedge pixel_clk_in) begin
        if (accept) begin
            start_p0 <= start_c;
            end_p0   <= end_c;
            wall_p0  <= wall_c;
            last_p0  <= col_last_in;
        end
    end

    // Stage p1: registered pixel stream; row 0 is produced on the handshake edge.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row_p1  <= '0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            pix_p1  <= '0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (oob_c) begin
                            last_p1 <= col_last_in;
                        end else begin
                            row_p1  <= '0;
                            addr_p1 <= 16'(col_x_in);
                            pix_p1  <= pick(8'd0, start_c, end_c, wall_c);
                            vld_p1  <= 1'b1;
                            last_p1 <= col_last_in && (ROW_LAST == 8'd0);
                        end
                    end
                end
                DRAW: begin
                    if (row_p1 != ROW_LAST) begin
                        row_p1  <= row_next;
                        addr_p1 <= addr_p1 + STRIDE;
                        pix_p1  <= pick(row_next, start_p0, end_p0, wall_p0);
                        vld_p1  <= 1'b1;
                        last_p1 <= last_p0 && (row_next == ROW_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ray_valid_out      = vld_p1;
    assign ray_address_out    = addr_p1;
    assign ray_pixel_out      = pix_p1;
    assign ray_last_pixel_out = last_p1;

endmodule

// File: tb/tb_fb_column_writer.sv
// Directed bench for fb_column_writer: strips, clamping, shading, frame end, swap wait, reset.
module tb_fb_column_writer;

    localparam logic [15:0] CEIL  = 16'h31A6;
    localparam logic [15:0] FLOOR = 16'h8410;

    logic        clk;
    logic        rst_n;
    logic        col_valid;
    logic        col_ready;
    logic [8:0]  col_x;
    logic [7:0]  col_height;
    logic [15:0] col_color;
    logic        col_side;
    logic        col_last;
    logic        frame_swap;
    logic        ray_valid;
    logic [15:0] ray_address;
    logic [15:0] ray_pixel;
    logic        ray_last;

    int n_vec;
    int n_bad;

    fb_column_writer dut (
        .pixel_clk_in       (clk),
        .rst_n_in           (rst_n),
        .col_valid_in       (col_valid),
        .col_ready_out      (col_ready),
        .col_x_in           (col_x),
        .col_height_in      (col_height),
        .col_color_in       (col_color),
        .col_side_in        (col_side),
        .col_last_in        (col_last),
        .frame_swap_in      (frame_swap),
        .ray_valid_out      (ray_valid),
        .ray_address_out    (ray_address),
        .ray_pixel_out      (ray_pixel),
        .ray_last_pixel_out (ray_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble();
        col_x      = 9'($urandom);
        col_height = 8'($urandom);
        col_color  = 16'($urandom);
        col_side   = 1'($urandom);
        col_last   = 1'($urandom);
    endtask

    // Called on a negedge with the DUT in IDLE; returns on the negedge after the strip.
    task automatic draw_col(input logic [8:0] x, input logic [7:0] h, input logic [15:0] color,
                            input logic side, input logic last, input int s, input int e,
                            input logic [15:0] wall, input int swap_at);
        logic [15:0] exp_pix;
        col_x      = x;
        col_height = h;
        col_color  = color;
        col_side   = side;
        col_last   = last;
        col_valid  = 1'b1;
        chk("rdy_pre", 32'(col_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        col_valid = 1'b0;
        scramble();
        for (int y = 0; y < 180; y++) begin
            exp_pix    = (y < s) ? CEIL : ((y < e) ? wall : FLOOR);
            frame_swap = (y == swap_at);
            chk("vld", 32'(ray_valid), 32'd1);
            chk("addr", 32'(ray_address), 32'(int'(x) + 320 * y));
            chk("pix", 32'(ray_pixel), 32'(exp_pix));
            chk("last", 32'(ray_last), 32'(last && (y == 179)));
            @(negedge clk);
        end
        frame_swap = 1'b0;
        chk("vld_end", 32'(ray_valid), 32'd0);
        chk("last_end", 32'(ray_last), 32'd0);
        chk("rdy_post", 32'(col_ready), 32'(!last));
    endtask

    task automatic pulse_swap();
        frame_swap = 1'b1;
        @(negedge clk);
        frame_swap = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        col_valid  = 1'b0;
        frame_swap = 1'b0;
        col_x      = '0;
        col_height = '0;
        col_color  = '0;
        col_side   = 1'b0;
        col_last   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(col_ready), 32'd0);
        chk("rst_vld", 32'(ray_valid), 32'd0);
        chk("rst_addr", 32'(ray_address), 32'd0);
        chk("rst_pix", 32'(ray_pixel), 32'd0);
        chk("rst_last", 32'(ray_last), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(col_ready), 32'd1);

        // Basic strip with a swap pulse mid-draw that must be ignored.
        draw_col(9'd5, 8'd100, 16'hF800, 1'b0, 1'b0, 40, 140, 16'hF800, 60);
        chk("addr_final", 32'(ray_address), 32'd57285);
        pulse_swap();
        chk("rdy_swap_idle", 32'(col_ready), 32'd1);

        // Back-to-back: clamped height with shading, then odd height.
        draw_col(9'd0, 8'd255, 16'hFFFF, 1'b1, 1'b0, 0, 180, 16'h7BEF, -1);
        draw_col(9'd100, 8'd101, 16'hF81F, 1'b1, 1'b0, 39, 140, 16'h780F, -1);

        // Final column of a frame: h=0, then hold in WAIT_SWAP despite a mid-draw swap.
        draw_col(9'd319, 8'd0, 16'h1234, 1'b0, 1'b1, 90, 90, 16'h1234, 30);
        repeat (3) begin
            @(negedge clk);
            chk("rdy_wait", 32'(col_ready), 32'd0);
            chk("vld_wait", 32'(ray_valid), 32'd0);
        end
        pulse_swap();
        chk("rdy_after_swap", 32'(col_ready), 32'd1);

        // Out-of-range column, not last: accepted, nothing emitted, straight back to IDLE.
        col_x = 9'd400; col_height = 8'd50; col_color = 16'hAAAA; col_side = 1'b0; col_last = 1'b0;
        col_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        col_valid = 1'b0;
        chk("oob_vld", 32'(ray_valid), 32'd0);
        chk("oob_last", 32'(ray_last), 32'd0);
        chk("oob_rdy", 32'(col_ready), 32'd1);

        // Out-of-range last column: lone last pulse with valid low, then WAIT_SWAP.
        col_x = 9'd400; col_last = 1'b1;
        col_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        col_valid = 1'b0;
        chk("oobl_vld", 32'(ray_valid), 32'd0);
        chk("oobl_last", 32'(ray_last), 32'd1);
        chk("oobl_rdy", 32'(col_ready), 32'd0);
        @(negedge clk);
        chk("oobl_last2", 32'(ray_last), 32'd0);
        chk("oobl_rdy2", 32'(col_ready), 32'd0);
        pulse_swap();
        chk("oobl_rdy_swap", 32'(col_ready), 32'd1);

        // Asynchronous reset in the middle of a strip.
        col_x = 9'd10; col_height = 8'd50; col_color = 16'h001F; col_side = 1'b0; col_last = 1'b0;
        col_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        col_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_vld", 32'(ray_valid), 32'd1);
        chk("mid_addr", 32'(ray_address), 32'd16010);
        chk("mid_pix", 32'(ray_pixel), 32'(CEIL));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(ray_valid), 32'd0);
        chk("arst_addr", 32'(ray_address), 32'd0);
        chk("arst_rdy", 32'(col_ready), 32'd0);
        @(negedge clk);
        chk("arst_hold_vld", 32'(ray_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_vld", 32'(ray_valid), 32'd0);
        draw_col(9'd7, 8'd20, 16'h07E0, 1'b1, 1'b0, 80, 100, 16'h03E0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_column_writer.md
Name: fb_column_writer

Overview:
- Write-side producer for the double-buffered 320x180 RGB565 frame buffer.
- Accepts one per-column wall descriptor from the raycaster/DDA stage (screen column, wall height, wall colour, side flag).
- Expands each descriptor into a vertical strip of SCREEN_HEIGHT pixels (ceiling / wall / floor).
- Drives the frame buffer's write address/data stream; flags the last pixel of each frame, then stalls until the buffers swap.

Parameters:
- SCREEN_WIDTH, 320, columns per frame; address row stride.
- SCREEN_HEIGHT, 180, pixels per column.
- CEIL_COLOR, 16'h31A6, RGB565 colour for rows above the wall.
- FLOOR_COLOR, 16'h8410, RGB565 colour for rows below the wall.

Ports:
- pixel_clk_in  input  1  pixel clock; all logic on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- col_valid_in  input  1  column descriptor valid.
- col_ready_out  output  1  block can accept a descriptor this cycle.
- col_x_in  input  9  screen column index.
- col_height_in  input  8  wall height in pixels; unclamped.
- col_color_in  input  16  RGB565 wall colour.
- col_side_in  input  1  y-side hit; wall is shaded.
- col_last_in  input  1  descriptor is the final column of the frame.
- frame_swap_in  input  1  one-cycle pulse when the frame buffers swap.
- ray_valid_out  output  1  ray_address_out/ray_pixel_out valid this cycle.
- ray_address_out  output  16  x + SCREEN_WIDTH*y.
- ray_pixel_out  output  16  RGB565 pixel.
- ray_last_pixel_out  output  1  one-cycle pulse on the final pixel of the frame.

Behaviour:
- Reset (rst_n_in low, asynchronous): state IDLE; col_ready_out=0 while reset is held; ray_valid_out=0; ray_address_out=0; ray_pixel_out=0; ray_last_pixel_out=0; all counters 0. Reset mid-strip abandons the strip; no further pixels are emitted.
- FSM states: IDLE, DRAW, WAIT_SWAP.
- IDLE:
  - col_ready_out=1 (combinational on state).
  - Handshake occurs when col_valid_in && col_ready_out; latch all col_* inputs; next state DRAW.
  - ray_valid_out=0.
- Capture arithmetic:
  - h = min(col_height_in, SCREEN_HEIGHT).
  - start = (SCREEN_HEIGHT - h) >> 1 (floor).
  - end = start + h.
  - Wall colour: if side=1, each channel shifts right by 1 ({r>>1, g>>1, b>>1} in 5/6/5 fields); otherwise col_color_in unchanged.
- DRAW:
  - col_ready_out=0.
  - One pixel per cycle for y = 0..SCREEN_HEIGHT-1; registered outputs.
  - First pixel (y=0) appears the cycle after the handshake.
  - ray_address_out starts at x and increments by SCREEN_WIDTH each row (no multiplier).
  - Pixel selection: y<start -> CEIL_COLOR; start<=y<end -> wall colour; y>=end -> FLOOR_COLOR.
  - After y=SCREEN_HEIGHT-1: if latched last=1, assert ray_last_pixel_out on that same pixel and go to WAIT_SWAP; otherwise go to IDLE.
  - Throughput: SCREEN_HEIGHT+1 cycles per column.
- Out-of-range x (col_x_in >= SCREEN_WIDTH): descriptor is accepted, no valid pixels are emitted, and the block returns to IDLE the next cycle. If last=1, pulse ray_last_pixel_out for one cycle with ray_valid_out=0, then go to WAIT_SWAP.
- WAIT_SWAP:
  - col_ready_out=0; outputs idle.
  - frame_swap_in=1 -> IDLE on the next edge.
- frame_swap_in is ignored in IDLE and DRAW; no sticky capture.
- h=0: start=end=SCREEN_HEIGHT/2, so the strip is all ceiling then floor.
- h>=SCREEN_HEIGHT: whole strip is wall colour.
- col_* inputs may change freely after the handshake; only latched values are used.
- Back-to-back columns: a new descriptor is accepted in the IDLE cycle immediately following DRAW.

Test Plan:
- Reset, then col x=5, h=100, color=16'hF800, side=0, last=0 -> 180 valid pixels. Addresses 5, 325, ... , 5+320*179=57285. y=0..39 CEIL_COLOR; y=40..139 16'hF800; y=140..179 FLOOR_COLOR. ray_last_pixel_out stays 0; block returns to IDLE.
- x=0, h=255, color=16'hFFFF, side=1 -> h clamped to 180; all 180 pixels 16'h7BEF.
- x=319, h=0, last=1 -> rows 0..89 CEIL_COLOR, rows 90..179 FLOOR_COLOR. ray_last_pixel_out high only with address 57599; col_ready_out stays 0 until a frame_swap_in pulse, and is 1 the cycle after it.
- frame_swap_in pulsed during DRAW and IDLE -> no state change. After a last column, the block still waits in WAIT_SWAP for the next pulse.
- x=400, last=1 -> no valid pixels; single ray_last_pixel_out pulse with valid=0; block enters WAIT_SWAP.
- rst_n_in dropped at y=50 of a strip -> valid=0 immediately (asynchronous). After release, col_ready_out=1 and the next descriptor draws from y=0.
